mem_arbiter: RTL and testbench

Two-requester arbiter sharing one single-port synchronous memory between the core's instruction-fetch path and its load/store path. It serialises accesses, latches each winning request, drives the memory for one cycle, waits out a fixed read latency, and returns data with a one-cycle ready pulse. It sits between the core (which stalls on `*_ready` low) and the unified instruction/data RAM.

---
 rtl/mem_arbiter.sv | 105 ++++++++++
 tb/tb_mem_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one single-port synchronous RAM between the
// instruction-fetch and load/store paths, serialising accesses with a fixed read latency.
module mem_arbiter #(
    parameter int LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t     state;
    logic       last_d;
    logic       win_d;
    logic [2:0] cnt;
    logic       pick_d;
    logic       unused_addr_bits;

    // On a tie the requester that did not win last time gets the grant.
    assign pick_d           = d_req & (~if_req | ~last_d);
    assign unused_addr_bits = ^{if_addr[1:0], d_addr[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last_d    <= 1'b0;
            win_d     <= 1'b0;
            cnt       <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ready  <= 1'b0;
            d_ready   <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (if_req | d_req) begin
                        win_d  <= pick_d;
                        last_d <= pick_d;
                        mem_en <= 1'b1;
                        if (pick_d) begin
                            mem_we    <= d_we;
                            mem_be    <= d_be;
                            mem_addr  <= {2'b00, d_addr[31:2]};
                            mem_wdata <= d_wdata;
                        end else begin
                            mem_we    <= 1'b0;
                            mem_be    <= '0;
                            mem_addr  <= {2'b00, if_addr[31:2]};
                            mem_wdata <= '0;
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_en <= 1'b0;
                    cnt    <= 3'(LAT);
                    state  <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        if (win_d) begin
                            d_rdata <= mem_rdata;
                            d_ready <= 1'b1;
                        end else begin
                            if_rdata <= mem_rdata;
                            if_ready <= 1'b1;
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    // No grant here, so a requester dropping req now is not served twice.
                    if_ready <= 1'b0;
                    d_ready  <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (LAT=1 and LAT=2) with behavioural RAMs,
// a table of single accesses, a ready scoreboard and hand-written contention/reset sequences.
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        if_req    [2];
    logic [31:0] if_addr   [2];
    logic        if_ready  [2];
    logic [31:0] if_rdata  [2];
    logic        d_req     [2];
    logic        d_we      [2];
    logic [3:0]  d_be      [2];
    logic [31:0] d_addr    [2];
    logic [31:0] d_wdata   [2];
    logic        d_ready   [2];
    logic [31:0] d_rdata   [2];
    logic        mem_en    [2];
    logic        mem_we    [2];
    logic [3:0]  mem_be    [2];
    logic [31:0] mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input logic [5:0] i);
        if (i == 6'd4) return 32'hDEAD_BEEF;
        return {8'hA5, 2'b00, i, 8'h5A, 2'b00, i};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        mem_arbiter #(.LAT(g + 1)) u_dut (
            .clk(clk), .rst(rst),
            .if_req(if_req[g]), .if_addr(if_addr[g]), .if_ready(if_ready[g]), .if_rdata(if_rdata[g]),
            .d_req(d_req[g]), .d_we(d_we[g]), .d_be(d_be[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
            .d_ready(d_ready[g]), .d_rdata(d_rdata[g]),
            .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_be(mem_be[g]), .mem_addr(mem_addr[g]),
            .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g])
        );

        logic [31:0] words  [64];
        logic [63:0] written;
        logic [31:0] pipe_d [g + 1];
        logic        pipe_v [g + 1];
        logic [5:0]  idx;
        logic [31:0] cur;
        logic [31:0] merged;

        assign idx = mem_addr[g][5:0];
        assign cur = written[idx] ? words[idx] : init_word(idx);

        always_comb begin
            merged = cur;
            for (int b = 0; b < 4; b++)
                if (mem_be[g][b]) merged[8*b +: 8] = mem_wdata[g][8*b +: 8];
        end

        always @(posedge clk) begin
            if (rst) written <= '0;
            else if (mem_en[g] && mem_we[g]) begin
                words[idx]   <= merged;
                written[idx] <= 1'b1;
            end
            pipe_v[0] <= mem_en[g];
            pipe_d[0] <= cur;
            for (int i = 1; i <= g; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_d[i] <= pipe_d[i-1];
            end
        end

        assign mem_rdata[g] = pipe_v[g] ? pipe_d[g] : 32'hBAD0_BAD0;
    end

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        int          k;
        bit          is_d;
        bit          chk;
        logic [31:0] data;
        int          c;
    } exp_t;
    exp_t sbq[$];
    exp_t mon_e;

    task automatic push(input int k, input bit is_d, input bit chk, input logic [31:0] data, input int c);
        exp_t e;
        e.k = k; e.is_d = is_d; e.chk = chk; e.data = data; e.c = c;
        sbq.push_back(e);
    endtask

    int   en_cnt [2];
    int   rdy_cnt[2];
    int   both_rdy  = 0;
    int   back2back = 0;
    logic en_prev[2];

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (mem_en[k] === 1'b1 && en_prev[k] === 1'b1) back2back <= back2back + 1;
            if (if_ready[k] === 1'b1 && d_ready[k] === 1'b1) both_rdy <= both_rdy + 1;
            en_prev[k] <= mem_en[k];
            if (mem_en[k] === 1'b1) en_cnt[k] <= en_cnt[k] + 1;
            if (if_ready[k] === 1'b1 || d_ready[k] === 1'b1) begin
                rdy_cnt[k] <= rdy_cnt[k] + 1;
                if (sbq.size() == 0) check("ready_expected", 32'(sbq.size()), 32'd1);
                else begin
                    mon_e = sbq.pop_front();
                    check("ready_port", {30'd0, 1'(k), d_ready[k]}, {30'd0, 1'(mon_e.k), mon_e.is_d});
                    check("ready_cycle", 32'(cyc), 32'(mon_e.c));
                    if (mon_e.chk)
                        check("ready_rdata", mon_e.is_d ? d_rdata[k] : if_rdata[k], mon_e.data);
                end
            end
        end
    end

    typedef struct {
        int          k;
        bit          is_d;
        bit          we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[8];

    task automatic clear_inputs();
        for (int k = 0; k < 2; k++) begin
            if_req[k] = 1'b0; if_addr[k] = '0;
            d_req[k] = 1'b0; d_we[k] = 1'b0; d_be[k] = '0; d_addr[k] = '0; d_wdata[k] = '0;
        end
    endtask

    task automatic check_reset_outputs();
        for (int k = 0; k < 2; k++) begin
            check("rst_mem_en", {31'd0, mem_en[k]}, 32'd0);
            check("rst_mem_addr", mem_addr[k], 32'd0);
            check("rst_mem_wdata", mem_wdata[k], 32'd0);
            check("rst_if_rdata", if_rdata[k], 32'd0);
            check("rst_d_rdata", d_rdata[k], 32'd0);
            check("rst_flags", {25'd0, if_ready[k], d_ready[k], mem_we[k], mem_be[k]}, 32'd0);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int  c0;
        bit  done;
        c0 = cyc;
        if (v.is_d) begin
            d_req[v.k] = 1'b1; d_we[v.k] = v.we; d_be[v.k] = v.be;
            d_addr[v.k] = v.addr; d_wdata[v.k] = v.wdata;
        end else begin
            if_req[v.k] = 1'b1; if_addr[v.k] = v.addr;
        end
        push(v.k, v.is_d, !v.we, v.exp, c0 + 3 + v.k);
        @(negedge clk);
        check("issue_en", {31'd0, mem_en[v.k]}, 32'd1);
        check("issue_addr", mem_addr[v.k], v.addr >> 2);
        check("issue_we", {31'd0, mem_we[v.k]}, {31'd0, v.we});
        if (!v.is_d) check("issue_fetch_be", {28'd0, mem_be[v.k]}, 32'd0);
        if (v.we) begin
            check("issue_be", {28'd0, mem_be[v.k]}, {28'd0, v.be});
            check("issue_wdata", mem_wdata[v.k], v.wdata);
        end
        done = 1'b0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if ((v.is_d ? d_ready[v.k] : if_ready[v.k]) === 1'b1) begin
                done = 1'b1;
                break;
            end
        end
        check("ready_seen", {31'd0, done}, 32'd1);
        if (v.is_d) d_req[v.k] = 1'b0;
        else if_req[v.k] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int c0;
        int r0;
        int e0;
        int nd;
        int ni;

        vecs[0] = '{k:0, is_d:0, we:0, be:4'h0, addr:32'h0000_0010, wdata:32'h0, exp:32'hDEAD_BEEF};
        vecs[1] = '{k:1, is_d:1, we:1, be:4'hF, addr:32'h0000_0020, wdata:32'h1234_5678, exp:32'h0};
        vecs[2] = '{k:1, is_d:1, we:0, be:4'h0, addr:32'h0000_0020, wdata:32'h0, exp:32'h1234_5678};
        vecs[3] = '{k:1, is_d:1, we:1, be:4'h2, addr:32'h0000_0020, wdata:32'h0000_AB00, exp:32'h0};
        vecs[4] = '{k:1, is_d:1, we:0, be:4'h0, addr:32'h0000_0020, wdata:32'h0, exp:32'h1234_AB78};
        vecs[5] = '{k:0, is_d:0, we:0, be:4'h0, addr:32'h0000_0044, wdata:32'h0, exp:init_word(6'd17)};
        vecs[6] = '{k:0, is_d:1, we:0, be:4'h0, addr:32'h0000_0044, wdata:32'h0, exp:init_word(6'd17)};
        vecs[7] = '{k:1, is_d:0, we:0, be:4'h0, addr:32'h0000_0010, wdata:32'h0, exp:32'hDEAD_BEEF};

        rst = 1'b1;
        clear_inputs();
        repeat (3) begin
            @(negedge clk);
            check("rst_hold_en", {31'd0, mem_en[0] | mem_en[1]}, 32'd0);
        end
        check_reset_outputs();
        rst = 1'b0;
        @(negedge clk);

        // Reset while a load is waiting on the LAT=2 memory.
        d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 32'h10;
        r0 = rdy_cnt[1];
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("rst_mid_en", {31'd0, mem_en[1]}, 32'd0);
        end
        check_reset_outputs();
        rst = 1'b0;
        d_req[1] = 1'b0;
        repeat (8) @(negedge clk);
        check("rst_abandon_ready", 32'(rdy_cnt[1] - r0), 32'd0);

        foreach (vecs[i]) run_vec(vecs[i]);

        apply_reset();

        // Tie straight after reset: data first, fetch on the next IDLE edge.
        c0 = cyc;
        if_req[0] = 1'b1; if_addr[0] = 32'h10;
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h8;
        push(0, 1'b1, 1'b1, init_word(6'd2), c0 + 3);
        push(0, 1'b0, 1'b1, 32'hDEAD_BEEF, c0 + 7);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (cyc == c0 + 5) begin
                check("tie_fetch_en", {31'd0, mem_en[0]}, 32'd1);
                check("tie_fetch_addr", mem_addr[0], 32'h4);
            end
            if (d_ready[0] === 1'b1) d_req[0] = 1'b0;
            if (if_ready[0] === 1'b1) if_req[0] = 1'b0;
            if (!d_req[0] && !if_req[0]) break;
        end
        check("tie_both_served", {30'd0, d_req[0], if_req[0]}, 32'd0);
        @(negedge clk);

        // Sustained contention on LAT=2: grants alternate D,I,... every LAT+3 cycles.
        c0 = cyc;
        nd = 0;
        ni = 0;
        d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 32'h100;
        if_req[1] = 1'b1; if_addr[1] = 32'h104;
        for (int j = 0; j < 8; j++)
            push(1, (j % 2) == 0, 1'b1, init_word(6'(j)), c0 + 4 + 5 * j);
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (d_ready[1] === 1'b1) begin
                nd++;
                if (nd < 4) d_addr[1] = 32'h100 + 32'(8 * nd);
                else d_req[1] = 1'b0;
            end
            if (if_ready[1] === 1'b1) begin
                ni++;
                if (ni < 4) if_addr[1] = 32'h104 + 32'(8 * ni);
                else if_req[1] = 1'b0;
            end
            if (nd == 4 && ni == 4) break;
        end
        check("contention_served", 32'(nd + ni), 32'd8);
        @(negedge clk);

        // Requester changes address and drops req during ISSUE.
        e0 = en_cnt[0];
        r0 = rdy_cnt[0];
        c0 = cyc;
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h30;
        push(0, 1'b1, 1'b1, init_word(6'd12), c0 + 3);
        @(negedge clk);
        check("mb_issue_addr", mem_addr[0], 32'hC);
        d_addr[0] = 32'h3C;
        d_req[0] = 1'b0;
        @(negedge clk);
        check("mb_addr_hold", mem_addr[0], 32'hC);
        repeat (6) @(negedge clk);
        check("mb_one_mem_en", 32'(en_cnt[0] - e0), 32'd1);
        check("mb_one_ready", 32'(rdy_cnt[0] - r0), 32'd1);

        check("one_ready_max", 32'(both_rdy), 32'd0);
        check("mem_en_back_to_back", 32'(back2back), 32'd0);
        check("scoreboard_drained", 32'(sbq.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
